// File: rtl/gift_param_enc.sv
// gift_param_enc -- iterative GIFT-64 / GIFT-128 block encryptor.
//
// A persistent 128-bit key register is loaded with inKeyWr while idle.
// inDataWr starts one encryption. Each RUN clock applies ROUNDS_PER_CYCLE
// complete GIFT rounds. The ciphertext appears on outData together with a
// one-cycle outValid pulse.
//
// Parameters
//   BLOCK_BITS        64 (28 rounds) or 128 (40 rounds)
//   ROUNDS_PER_CYCLE  1, 2 or 4 rounds unrolled per clock
//
// Ports
//   inClk       in   1           clock, rising edge
//   inRst       in   1           asynchronous active-high reset
//   inKeyWr     in   1           key load strobe (ignored while busy)
//   inKeyData   in   128         master key, bit 0 = LSB
//   inDataWr    in   1           plaintext load + start strobe (ignored while busy)
//   inDataData  in   BLOCK_BITS  plaintext, bit 0 = LSB
//   outData     out  BLOCK_BITS  last ciphertext, held until the next block completes
//   outBusy     out  1           encryption in progress
//   outValid    out  1           one-cycle completion pulse
module gift_param_enc #(
   parameter int BLOCK_BITS       = 128,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                  inClk,
   input  logic                  inRst,
   input  logic                  inKeyWr,
   input  logic [127:0]          inKeyData,
   input  logic                  inDataWr,
   input  logic [BLOCK_BITS-1:0] inDataData,
   output logic [BLOCK_BITS-1:0] outData,
   output logic                  outBusy,
   output logic                  outValid
);

   localparam int         ROUNDS   = (BLOCK_BITS == 64) ? 28 : 40;
   localparam int         CYCLES   = ROUNDS / ROUNDS_PER_CYCLE;
   localparam int         IW       = $clog2(BLOCK_BITS);
   localparam logic [5:0] LAST_CNT = 6'(CYCLES - 1);

   generate
      if (BLOCK_BITS != 64 && BLOCK_BITS != 128) begin : g_bad_block_bits
         $error("gift_param_enc: BLOCK_BITS must be 64 or 128");
      end
      if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
         $error("gift_param_enc: ROUNDS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   // ------------------------------------------------------------------
   // GIFT round primitives
   // ------------------------------------------------------------------
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h1;  4'h1: y = 4'ha;  4'h2: y = 4'h4;  4'h3: y = 4'hc;
         4'h4: y = 4'h6;  4'h5: y = 4'hf;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
         4'h8: y = 4'h2;  4'h9: y = 4'hd;  4'ha: y = 4'hb;  4'hb: y = 4'h7;
         4'hc: y = 4'h5;  4'hd: y = 4'h0;  4'he: y = 4'h8;  default: y = 4'he;
      endcase
      return y;
   endfunction

   function automatic logic [BLOCK_BITS-1:0] sub_cells(input logic [BLOCK_BITS-1:0] s);
      logic [BLOCK_BITS-1:0] r;
      logic [IW-1:0]         b;
      r = '0;
      for (int i = 0; i < BLOCK_BITS / 4; i++) begin
         b        = IW'(4 * i);
         r[b+:4]  = sbox(s[b+:4]);
      end
      return r;
   endfunction

   // Bit i moves to 4*(i/16) + (n/4)*((3*((i%16)/4) + i%4) % 4) + i%4.
   function automatic logic [BLOCK_BITS-1:0] perm_bits(input logic [BLOCK_BITS-1:0] s);
      logic [BLOCK_BITS-1:0] r;
      logic [IW-1:0]         src;
      logic [IW-1:0]         dst;
      r = '0;
      for (int i = 0; i < BLOCK_BITS; i++) begin
         src    = IW'(i);
         dst    = IW'(4 * (i / 16) + (BLOCK_BITS / 4) * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4));
         r[dst] = s[src];
      end
      return r;
   endfunction

   // GIFT-64 : U = k1, V = k0, u_i -> bit 4i+1, v_i -> bit 4i.
   // GIFT-128: U = k5||k4, V = k1||k0, u_i -> bit 4i+2, v_i -> bit 4i+1.
   function automatic logic [BLOCK_BITS-1:0] add_round_key(input logic [BLOCK_BITS-1:0] s,
                                                          input logic [127:0]          k);
      logic [BLOCK_BITS-1:0] r;
      logic [IW-1:0]         pu;
      logic [IW-1:0]         pv;
      logic [6:0]            ku;
      logic [6:0]            kv;
      r = s;
      for (int i = 0; i < BLOCK_BITS / 4; i++) begin
         if (BLOCK_BITS == 64) begin
            pu = IW'(4 * i + 1);
            pv = IW'(4 * i);
            ku = 7'(16 + i);
         end else begin
            pu = IW'(4 * i + 2);
            pv = IW'(4 * i + 1);
            ku = 7'(64 + i);
         end
         kv    = 7'(i);
         r[pu] = r[pu] ^ k[ku];
         r[pv] = r[pv] ^ k[kv];
      end
      return r;
   endfunction

   function automatic logic [BLOCK_BITS-1:0] add_const(input logic [BLOCK_BITS-1:0] s,
                                                      input logic [5:0]            c);
      logic [BLOCK_BITS-1:0] r;
      r                = s;
      r[BLOCK_BITS-1]  = ~r[BLOCK_BITS-1];
      r[23]            = r[23] ^ c[5];
      r[19]            = r[19] ^ c[4];
      r[15]            = r[15] ^ c[3];
      r[11]            = r[11] ^ c[2];
      r[7]             = r[7]  ^ c[1];
      r[3]             = r[3]  ^ c[0];
      return r;
   endfunction

   // k7..k0 <- (k1 >>> 2) || (k0 >>> 12) || k7 .. k2
   function automatic logic [127:0] key_step(input logic [127:0] k);
      return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
   endfunction

   function automatic logic [5:0] lfsr_step(input logic [5:0] c);
      return {c[4:0], c[5] ^ c[4] ^ 1'b1};
   endfunction

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  start;
   logic                  last;
   logic [5:0]            rnd_cnt;
   logic [5:0]            lfsr;
   logic [127:0]          key_reg;
   logic [127:0]          rk_reg;
   logic [BLOCK_BITS-1:0] st_reg;
   logic [BLOCK_BITS-1:0] ct_reg;
   logic [BLOCK_BITS-1:0] st_nxt;
   logic [127:0]          rk_nxt;
   logic [5:0]            rc_nxt;

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      last      = 1'b0;
      outBusy   = 1'b0;
      outValid  = 1'b0;
      case (state)
         S_IDLE: begin
            if (inDataWr) begin
               start     = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            outBusy = 1'b1;
            if (rnd_cnt == LAST_CNT) begin
               last      = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            outValid = 1'b1;
            if (inDataWr) begin
               start     = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Unrolled round datapath: the constant is stepped before use, so a
   // cleared LFSR yields 0x01 for the first round.
   // ------------------------------------------------------------------
   always_comb begin
      st_nxt = st_reg;
      rk_nxt = rk_reg;
      rc_nxt = lfsr;
      for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
         rc_nxt = lfsr_step(rc_nxt);
         st_nxt = add_const(add_round_key(perm_bits(sub_cells(st_nxt)), rk_nxt), rc_nxt);
         rk_nxt = key_step(rk_nxt);
      end
   end

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         key_reg <= '0;
         rk_reg  <= '0;
         st_reg  <= '0;
         ct_reg  <= '0;
         lfsr    <= '0;
         rnd_cnt <= '0;
      end else begin
         // Key writes are only honoured outside RUN.
         if (state != S_RUN && inKeyWr) key_reg <= inKeyData;
         if (start) begin
            st_reg  <= inDataData;
            rk_reg  <= inKeyWr ? inKeyData : key_reg;
            lfsr    <= '0;
            rnd_cnt <= '0;
         end else if (state == S_RUN) begin
            st_reg  <= st_nxt;
            rk_reg  <= rk_nxt;
            lfsr    <= rc_nxt;
            rnd_cnt <= rnd_cnt + 6'd1;
            if (last) ct_reg <= st_nxt;
         end
      end
   end

   // ct_reg equals the state register in DONE/IDLE and keeps the previous
   // ciphertext visible while a new block runs.
   assign outData = ct_reg;

endmodule

// File: tb/tb_gift_param_enc.sv
// tb_gift_param_enc -- directed-vector bench for gift_param_enc.
// Three instances: GIFT-128 x1 round/clk, GIFT-128 x4, GIFT-64 x2.
// Expected ciphertexts are the published GIFT reference test vectors.
module tb_gift_param_enc;

   localparam logic [127:0] KF      = 128'hfedcba9876543210fedcba9876543210;
   localparam logic [127:0] PF      = 128'hfedcba9876543210fedcba9876543210;
   localparam logic [127:0] PF64    = 128'h0000000000000000fedcba9876543210;
   localparam logic [127:0] KR      = 128'hd0f5c59a7700d3e799028fa9f90ad837;
   localparam logic [127:0] PR      = 128'he39c141fa57dba43f08a85b6a91f86c1;
   localparam logic [127:0] CT128_Z = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
   localparam logic [127:0] CT128_F = 128'h8422241a6dbf5a9346af468409ee0152;
   localparam logic [127:0] CT128_R = 128'h13ede67cbdcc3dbf400a62d6977265ea;
   localparam logic [127:0] CT64_Z  = 128'h0000000000000000f62bc3ef34f775ac;
   localparam logic [127:0] CT64_F  = 128'h0000000000000000c1b71f66160ff587;

   logic         clk;
   logic         rst;
   logic         kw [0:2];
   logic         dw [0:2];
   logic [127:0] kd [0:2];
   logic [127:0] dd [0:2];
   logic         b0, b1, b2;
   logic         v0, v1, v2;
   logic [127:0] q0, q1;
   logic [63:0]  q2;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           nb;
   logic [127:0] ct;

   gift_param_enc #(.BLOCK_BITS(128), .ROUNDS_PER_CYCLE(1)) u_r1 (
      .inClk(clk), .inRst(rst), .inKeyWr(kw[0]), .inKeyData(kd[0]),
      .inDataWr(dw[0]), .inDataData(dd[0]), .outData(q0), .outBusy(b0), .outValid(v0));

   gift_param_enc #(.BLOCK_BITS(128), .ROUNDS_PER_CYCLE(4)) u_r4 (
      .inClk(clk), .inRst(rst), .inKeyWr(kw[1]), .inKeyData(kd[1]),
      .inDataWr(dw[1]), .inDataData(dd[1]), .outData(q1), .outBusy(b1), .outValid(v1));

   gift_param_enc #(.BLOCK_BITS(64), .ROUNDS_PER_CYCLE(2)) u_b64 (
      .inClk(clk), .inRst(rst), .inKeyWr(kw[2]), .inKeyData(kd[2]),
      .inDataWr(dw[2]), .inDataData(dd[2][63:0]), .outData(q2), .outBusy(b2), .outValid(v2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic busy_of(input logic [1:0] u);
      case (u)
         2'd0:    return b0;
         2'd1:    return b1;
         default: return b2;
      endcase
   endfunction

   function automatic logic valid_of(input logic [1:0] u);
      case (u)
         2'd0:    return v0;
         2'd1:    return v1;
         default: return v2;
      endcase
   endfunction

   function automatic logic [127:0] data_of(input logic [1:0] u);
      case (u)
         2'd0:    return q0;
         2'd1:    return q1;
         default: return {64'd0, q2};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [1:0] u, input logic kwr, input logic [127:0] key,
                        input logic [127:0] pt);
      kw[u] = kwr;
      kd[u] = key;
      dw[u] = 1'b1;
      dd[u] = pt;
      @(posedge clk);
      #1;
      kw[u] = 1'b0;
      dw[u] = 1'b0;
   endtask

   // Counts busy cycles until outValid; returns at the negedge that sees it.
   task automatic wait_done(input logic [1:0] u, input string tag, output int busy_cnt,
                            output logic [127:0] ct_out);
      busy_cnt = 0;
      ct_out   = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (valid_of(u)) begin
            ct_out = data_of(u);
            return;
         end
         if (busy_of(u)) busy_cnt++;
      end
      chk({tag, "_timeout"}, 128'(valid_of(u)), 128'd1);
   endtask

   // One cycle after DONE: pulse gone, not busy, ciphertext held.
   task automatic after_done(input logic [1:0] u, input string tag, input logic [127:0] exp);
      @(negedge clk);
      chk({tag, "_valid_drop"}, 128'(valid_of(u)), 128'd0);
      chk({tag, "_idle_busy"},  128'(busy_of(u)),  128'd0);
      chk({tag, "_hold"},       data_of(u),        exp);
   endtask

   initial begin
      rst = 1'b1;
      kw  = '{1'b0, 1'b0, 1'b0};
      dw  = '{1'b0, 1'b0, 1'b0};
      kd  = '{128'd0, 128'd0, 128'd0};
      dd  = '{128'd0, 128'd0, 128'd0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy_r1",  128'(b0), 128'd0);
      chk("rst_valid_r1", 128'(v0), 128'd0);
      chk("rst_data_r1",  q0, 128'd0);
      chk("rst_data_b64", {64'd0, q2}, 128'd0);

      // Zero key / zero plaintext, started on the first edge after reset.
      rst = 1'b0;
      start(2'd0, 1'b1, 128'd0, 128'd0);
      wait_done(2'd0, "z128", nb, ct);
      chk("z128_busy", 128'(nb), 128'd40);
      chk("z128_ct", ct, CT128_Z);
      after_done(2'd0, "z128", CT128_Z);

      // Same fedcba vector at 4 and 1 rounds per clock.
      start(2'd1, 1'b1, KF, PF);
      wait_done(2'd1, "f128_r4", nb, ct);
      chk("f128_r4_busy", 128'(nb), 128'd10);
      chk("f128_r4_ct", ct, CT128_F);
      after_done(2'd1, "f128_r4", CT128_F);

      start(2'd0, 1'b1, KF, PF);
      wait_done(2'd0, "f128_r1", nb, ct);
      chk("f128_r1_busy", 128'(nb), 128'd40);
      chk("f128_r1_ct", ct, CT128_F);
      after_done(2'd0, "f128_r1", CT128_F);

      // GIFT-64: key written alone, plaintext started two cycles later.
      kw[2] = 1'b1;
      kd[2] = KF;
      @(posedge clk); #1;
      kw[2] = 1'b0;
      kd[2] = '0;
      @(posedge clk); #1;
      start(2'd2, 1'b0, 128'd0, PF64);
      wait_done(2'd2, "f64", nb, ct);
      chk("f64_busy", 128'(nb), 128'd14);
      chk("f64_ct", ct, CT64_F);
      after_done(2'd2, "f64", CT64_F);

      // Back-to-back blocks under one stored key, restart issued in DONE.
      kw[0] = 1'b1;
      kd[0] = KR;
      @(posedge clk); #1;
      kw[0] = 1'b0;
      start(2'd0, 1'b0, 128'd0, PR);
      wait_done(2'd0, "b2b_a", nb, ct);
      chk("b2b_a_ct", ct, CT128_R);
      start(2'd0, 1'b0, 128'd0, PR);
      wait_done(2'd0, "b2b_b", nb, ct);
      chk("b2b_b_busy", 128'(nb), 128'd40);
      chk("b2b_b_ct", ct, CT128_R);
      // New key written together with the start strobe in DONE.
      start(2'd0, 1'b1, 128'd0, 128'd0);
      wait_done(2'd0, "b2b_c", nb, ct);
      chk("b2b_c_busy", 128'(nb), 128'd40);
      chk("b2b_c_ct", ct, CT128_Z);
      after_done(2'd0, "b2b_c", CT128_Z);
      // That key must have been stored as well.
      start(2'd0, 1'b0, 128'd0, 128'd0);
      wait_done(2'd0, "keep", nb, ct);
      chk("keep_ct", ct, CT128_Z);
      after_done(2'd0, "keep", CT128_Z);

      // Strobes during RUN are ignored.
      start(2'd0, 1'b0, 128'd0, 128'd0);
      repeat (5) @(posedge clk);
      #1;
      kw[0] = 1'b1; kd[0] = KF; dw[0] = 1'b1; dd[0] = PF;
      @(posedge clk); #1;
      kw[0] = 1'b0; dw[0] = 1'b0;
      @(negedge clk);
      chk("ign_busy", 128'(b0), 128'd1);
      chk("ign_prev_ct", q0, CT128_Z);
      wait_done(2'd0, "ign", nb, ct);
      chk("ign_busy_left", 128'(nb), 128'd33);
      chk("ign_ct", ct, CT128_Z);
      after_done(2'd0, "ign", CT128_Z);
      start(2'd0, 1'b0, 128'd0, 128'd0);
      wait_done(2'd0, "ign_next", nb, ct);
      chk("ign_next_ct", ct, CT128_Z);
      after_done(2'd0, "ign_next", CT128_Z);

      // Reset in the middle of a run with a nonzero key.
      start(2'd0, 1'b1, KF, PF);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_busy",  128'(b0), 128'd0);
      chk("mrst_valid", 128'(v0), 128'd0);
      chk("mrst_data",  q0, 128'd0);
      chk("mrst_data_r4", q1, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      start(2'd0, 1'b0, 128'd0, 128'd0);
      wait_done(2'd0, "mrst_re", nb, ct);
      chk("mrst_re_busy", 128'(nb), 128'd40);
      chk("mrst_re_ct", ct, CT128_Z);

      // Key registers of the other instances were cleared by the reset too.
      start(2'd1, 1'b0, 128'd0, 128'd0);
      wait_done(2'd1, "z128_r4", nb, ct);
      chk("z128_r4_busy", 128'(nb), 128'd10);
      chk("z128_r4_ct", ct, CT128_Z);

      start(2'd2, 1'b0, 128'd0, 128'd0);
      wait_done(2'd2, "z64", nb, ct);
      chk("z64_busy", 128'(nb), 128'd14);
      chk("z64_ct", ct, CT64_Z);
      after_done(2'd2, "z64", CT64_Z);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gift_param_enc.md
GIFT_PARAM_ENC -- requirements
Module: gift_param_enc

Interface
REQ-001 SHALL have parameter BLOCK_BITS, default 128; GIFT block size, legal values 64 (28 rounds) or 128 (40 rounds).
REQ-002 SHALL have parameter ROUNDS_PER_CYCLE, default 1; rounds unrolled per clock, legal values 1, 2 or 4.
REQ-003 SHALL reject illegal parameter values at elaboration.
REQ-004 SHALL have port inClk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port inRst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port inKeyWr, input, 1 bit: key load strobe.
REQ-007 SHALL have port inKeyData, input, 128 bits: master key.
REQ-008 SHALL have port inDataWr, input, 1 bit: plaintext load and start strobe.
REQ-009 SHALL have port inDataData, input, BLOCK_BITS bits: plaintext.
REQ-010 SHALL have port outData, output, BLOCK_BITS bits: ciphertext.
REQ-011 SHALL have port outBusy, output, 1 bit: encryption in progress.
REQ-012 SHALL have port outValid, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL hold a persistent 128-bit key register, written by inKeyWr in IDLE and reused for every later block until rewritten (no per-block key reload required).
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-015 SHALL, on an edge in IDLE or DONE with inDataWr=1: load inDataData into the state register, copy the key register into the round-key register, clear the 6-bit round-constant LFSR to 0, reset the round counter, and enter RUN.
REQ-016 SHALL, if inKeyWr and inDataWr are both high on that start edge, encrypt with the newly written inKeyData and also store it in the key register.
REQ-017 SHALL apply ROUNDS_PER_CYCLE complete GIFT rounds per RUN edge: SubCells, PermBits, AddRoundKey, AddConstant, key-schedule update, and LFSR update.
REQ-018 SHALL take exactly N = R/ROUNDS_PER_CYCLE RUN edges per block, where R is 28 or 40 (N = 40/20/10 for GIFT-128 and 28/14/7 for GIFT-64).
REQ-019 SHALL assert outBusy in RUN only; outBusy is high from the start edge through the last round edge.
REQ-020 SHALL, after the Nth round edge, enter DONE: outValid=1 for exactly one cycle, outBusy=0, outData=ciphertext.
REQ-021 SHALL hold outData stable from DONE until the next start edge; outData shows the state register only in DONE/IDLE and the last ciphertext otherwise.
REQ-022 SHALL ignore inDataWr and inKeyWr while outBusy=1; the key register and the running encryption are unaffected.
REQ-023 SHALL accept a new inDataWr in DONE, giving back-to-back blocks with one idle-free turnaround cycle.
REQ-024 SHALL match the GIFT-64/GIFT-128 specification bit ordering: bit 0 is the LSB of inDataData and inKeyData.

Reset
REQ-025 SHALL, on inRst=1 at any time including mid-RUN: FSM=IDLE, outBusy=0, outValid=0, outData=0, key register=0, state=0, LFSR=0, round counter=0.
REQ-026 SHALL accept inDataWr on the first edge after inRst deasserts and encrypt with the all-zero key.

Verification
REQ-027 SHALL pass this scenario: default parameters, key=0, pt=0 written together -> outBusy high for 40 cycles, outValid pulse, outData equals the golden-model GIFT-128 value.
REQ-028 SHALL pass this scenario: ROUNDS_PER_CYCLE=4, key=pt=fedcba9876543210fedcba9876543210 -> busy for 10 cycles, ciphertext identical to the ROUNDS_PER_CYCLE=1 run.
REQ-029 SHALL pass this scenario: BLOCK_BITS=64, ROUNDS_PER_CYCLE=2, key written alone, then pt=fedcba9876543210 two cycles later -> busy for 14 cycles, outData equals the golden-model GIFT-64 value.
REQ-030 SHALL pass this scenario: key loaded once, then two blocks with inDataWr asserted in DONE -> both ciphertexts correct, second start accepted with no gap.
REQ-031 SHALL pass this scenario: inKeyWr=1 with a new key and inDataWr=1 mid-RUN -> current ciphertext unchanged, key register still holds the old key on the next block.
REQ-032 SHALL pass this scenario: inRst pulsed at round 5 -> outputs 0 immediately, no outValid; restart pt=0 with key=0 -> result equal to REQ-027.
